// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - select clamp, circular tap addressing and reset constants for shifter_2d_taps
package shifter_pkg;

  localparam logic RST_FLAG = 1'b0;

  function automatic int unsigned clamp_sel(int unsigned sel, int unsigned depth);
    return (sel >= depth) ? depth - 1 : sel;
  endfunction

  // Slot holding the word 'sel' positions older than the newest; DEPTH need not be a power of two.
  function automatic int unsigned tap_addr(int unsigned wp, int unsigned sel, int unsigned depth);
    int unsigned a;
    a = wp + depth - 1 - clamp_sel(sel, depth);
    if (a >= depth) a = a - depth;
    return a;
  endfunction

endpackage

// File: rtl/shifter_tap.sv
// rtl/shifter_tap.sv - one registered delay tap of shifter_2d_taps
// SHIFTER_FILL_TRACK_EN: valid follows the fill counter; otherwise valid is 1 outside reset.
module shifter_tap
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [SW-1:0]               sel,
  input  logic [SW-1:0]               wp,
`ifdef SHIFTER_FILL_TRACK_EN
  input  logic [$clog2(DEPTH+1)-1:0]  fc,
`endif
  input  logic [DEPTH*WIDTH-1:0]      mem_flat,
  output logic [WIDTH-1:0]            word,
  output logic                        valid
);

  typedef logic [SW-1:0] tap_sel_t;

  tap_sel_t addr;
  logic     fill_ok;

  assign addr = tap_sel_t'(tap_addr(32'(wp), 32'(sel), DEPTH));

`ifdef SHIFTER_FILL_TRACK_EN
  assign fill_ok = 32'(fc) > clamp_sel(32'(sel), DEPTH);
`else
  assign fill_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      word  <= '0;
      valid <= RST_FLAG;
    end else begin
      word  <= mem_flat[addr*WIDTH +: WIDTH];
      valid <= fill_ok;
    end
  end

endmodule

// File: rtl/shifter_2d_taps.sv
// rtl/shifter_2d_taps.sv - multi-tap circular word delay line with registered taps
// SHIFTER_FILL_TRACK_EN enables the fill counter behind tap_valid and lleno.
module shifter_2d_taps
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int N_TAPS = 4,
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [WIDTH-1:0]        entrada_serie,
  input  logic [N_TAPS*SW-1:0]    seleccion,
  output logic [N_TAPS*WIDTH-1:0] salida_taps,
  output logic [N_TAPS-1:0]       tap_valid,
  output logic [WIDTH-1:0]        salida_serie,
  output logic                    lleno
);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [SW-1:0]          wp;
  logic [SW-1:0]          oldest_addr;
  logic                   flush;
  logic                   full;

  assign flush = reset | clear;

  always_ff @(posedge clock) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
    end else if (enable) begin
      mem[wp] <= entrada_serie;
      wp      <= (32'(wp) == DEPTH - 1) ? '0 : wp + 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign mem_flat[i*WIDTH +: WIDTH] = mem[i];
  end

`ifdef SHIFTER_FILL_TRACK_EN
  localparam int FCW = $clog2(DEPTH + 1);
  logic [FCW-1:0] fc;

  always_ff @(posedge clock) begin
    if (flush)                              fc <= '0;
    else if (enable && (32'(fc) != DEPTH))  fc <= fc + 1'b1;
  end

  assign full = (32'(fc) == DEPTH);
`else
  assign full = 1'b1;
`endif

  // Oldest word sits at wp itself: the slot that the next enabled write overwrites.
  assign oldest_addr = SW'(tap_addr(32'(wp), DEPTH - 1, DEPTH));

  // Outputs are cleared by reset only, so a clear shows pre-clear data for one more cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      salida_serie <= '0;
      lleno        <= RST_FLAG;
    end else begin
      salida_serie <= mem[oldest_addr];
      lleno        <= full;
    end
  end

  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    shifter_tap #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_tap (
      .clock    (clock),
      .reset    (reset),
      .sel      (seleccion[k*SW +: SW]),
      .wp       (wp),
`ifdef SHIFTER_FILL_TRACK_EN
      .fc       (fc),
`endif
      .mem_flat (mem_flat),
      .word     (salida_taps[k*WIDTH +: WIDTH]),
      .valid    (tap_valid[k])
    );
  end

endmodule

// File: tb/tb_shifter_2d_taps.sv
// tb/tb_shifter_2d_taps.sv - directed self-checking bench for shifter_2d_taps
module tb_shifter_2d_taps;

  localparam int W = 8, D = 32, NT = 4, SW = 5, D5 = 5, SW5 = 3;
`ifdef SHIFTER_FILL_TRACK_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset, clear, enable;
  logic [W-1:0]    din;
  logic [NT*SW-1:0] sel;
  logic [NT*W-1:0] taps;
  logic [NT-1:0]   tv;
  logic [W-1:0]    serie;
  logic            lleno;

  logic            enable5, clear5;
  logic [W-1:0]    din5;
  logic [SW5-1:0]  sel5;
  logic [W-1:0]    taps5;
  logic            tv5;
  logic [W-1:0]    serie5;
  logic            lleno5;

  int pass_cnt = 0;
  int total_cnt = 0;

  shifter_2d_taps #(.WIDTH(W), .DEPTH(D), .N_TAPS(NT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .entrada_serie(din), .seleccion(sel), .salida_taps(taps),
    .tap_valid(tv), .salida_serie(serie), .lleno(lleno)
  );

  shifter_2d_taps #(.WIDTH(W), .DEPTH(D5), .N_TAPS(1)) dut5 (
    .clock(clock), .reset(reset), .enable(enable5), .clear(clear5),
    .entrada_serie(din5), .seleccion(sel5), .salida_taps(taps5),
    .tap_valid(tv5), .salida_serie(serie5), .lleno(lleno5)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_sel(input int s0, input int s1, input int s2, input int s3);
    sel = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; din = 8'hAA;
    repeat (3) tick();
    total_cnt++; if (taps !== 32'h0) $display("FAIL reset_taps: got %h expected %h", taps, 32'h0); else pass_cnt++;
    total_cnt++; if (serie !== 8'h0) $display("FAIL reset_serie: got %h expected %h", serie, 8'h0); else pass_cnt++;
    total_cnt++; if (tv !== 4'b0) $display("FAIL reset_valid: got %b expected %b", tv, 4'b0); else pass_cnt++;
    total_cnt++; if (lleno !== 1'b0) $display("FAIL reset_lleno: got %b expected %b", lleno, 1'b0); else pass_cnt++;
    total_cnt++; if (taps5 !== 8'h0) $display("FAIL reset_taps5: got %h expected %h", taps5, 8'h0); else pass_cnt++;
    reset = 1'b0; enable = 1'b0;
  endtask

  task automatic test_fill();
    logic [NT-1:0] exp_v;
    logic          exp_l;
    set_sel(0, 1, 5, 31);
    for (int i = 1; i <= 32; i++) begin
      din = W'(i); enable = 1'b1;
      tick();
      if (i == 4) begin
        exp_v = FILL ? 4'b0011 : 4'b1111;
        exp_l = FILL ? 1'b0 : 1'b1;
        total_cnt++; if (taps !== 32'h0000_0203) $display("FAIL fill3_taps: got %h expected %h", taps, 32'h0000_0203); else pass_cnt++;
        total_cnt++; if (tv !== exp_v) $display("FAIL fill3_valid: got %b expected %b", tv, exp_v); else pass_cnt++;
        total_cnt++; if (lleno !== exp_l) $display("FAIL fill3_lleno: got %b expected %b", lleno, exp_l); else pass_cnt++;
      end
    end
    enable = 1'b0;
    tick();
    total_cnt++; if (taps !== 32'h011B_1F20) $display("FAIL full_taps: got %h expected %h", taps, 32'h011B_1F20); else pass_cnt++;
    total_cnt++; if (tv !== 4'b1111) $display("FAIL full_valid: got %b expected %b", tv, 4'b1111); else pass_cnt++;
    total_cnt++; if (lleno !== 1'b1) $display("FAIL full_lleno: got %b expected %b", lleno, 1'b1); else pass_cnt++;
    total_cnt++; if (serie !== 8'd1) $display("FAIL full_serie: got %0d expected %0d", serie, 1); else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int i = 33; i <= 40; i++) begin
      din = W'(i); enable = 1'b1;
      tick();
    end
    enable = 1'b0;
    tick();
    total_cnt++; if (taps !== 32'h0923_2728) $display("FAIL wrap_taps: got %h expected %h", taps, 32'h0923_2728); else pass_cnt++;
    total_cnt++; if (serie !== 8'd9) $display("FAIL wrap_serie: got %0d expected %0d", serie, 9); else pass_cnt++;
    total_cnt++; if (lleno !== 1'b1) $display("FAIL wrap_lleno: got %b expected %b", lleno, 1'b1); else pass_cnt++;
  endtask

  task automatic test_hold();
    enable = 1'b0; din = 8'hEE;
    set_sel(7, 1, 5, 31);
    #1;
    total_cnt++; if (taps[7:0] !== 8'd40) $display("FAIL hold_pre_edge: got %0d expected %0d", taps[7:0], 40); else pass_cnt++;
    tick();
    total_cnt++; if (taps !== 32'h0923_2721) $display("FAIL hold_sel_change: got %h expected %h", taps, 32'h0923_2721); else pass_cnt++;
    repeat (4) tick();
    total_cnt++; if (taps !== 32'h0923_2721) $display("FAIL hold_taps: got %h expected %h", taps, 32'h0923_2721); else pass_cnt++;
    total_cnt++; if (serie !== 8'd9) $display("FAIL hold_serie: got %0d expected %0d", serie, 9); else pass_cnt++;
  endtask

  task automatic test_clear();
    logic [NT-1:0] exp_v;
    logic          exp_l;
    set_sel(0, 1, 5, 31);
    clear = 1'b1; enable = 1'b1; din = 8'h55;
    tick();
    total_cnt++; if (taps !== 32'h0923_2728) $display("FAIL clear_pre_taps: got %h expected %h", taps, 32'h0923_2728); else pass_cnt++;
    total_cnt++; if (lleno !== 1'b1) $display("FAIL clear_pre_lleno: got %b expected %b", lleno, 1'b1); else pass_cnt++;
    clear = 1'b0; enable = 1'b0;
    tick();
    exp_v = FILL ? 4'b0000 : 4'b1111;
    exp_l = FILL ? 1'b0 : 1'b1;
    total_cnt++; if (taps !== 32'h0) $display("FAIL clear_taps: got %h expected %h", taps, 32'h0); else pass_cnt++;
    total_cnt++; if (serie !== 8'h0) $display("FAIL clear_serie: got %h expected %h", serie, 8'h0); else pass_cnt++;
    total_cnt++; if (tv !== exp_v) $display("FAIL clear_valid: got %b expected %b", tv, exp_v); else pass_cnt++;
    total_cnt++; if (lleno !== exp_l) $display("FAIL clear_lleno: got %b expected %b", lleno, exp_l); else pass_cnt++;
    din = 8'h11; enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    exp_v = FILL ? 4'b0001 : 4'b1111;
    total_cnt++; if (taps !== 32'h0000_0011) $display("FAIL post_clear_taps: got %h expected %h", taps, 32'h0000_0011); else pass_cnt++;
    total_cnt++; if (tv !== exp_v) $display("FAIL post_clear_valid: got %b expected %b", tv, exp_v); else pass_cnt++;
    total_cnt++; if (serie !== 8'h0) $display("FAIL post_clear_serie: got %h expected %h", serie, 8'h0); else pass_cnt++;
  endtask

  task automatic test_clamp_odd();
    logic exp_v;
    sel5 = 3'd7;
    for (int i = 1; i <= 6; i++) begin
      din5 = W'(i); enable5 = 1'b1;
      tick();
      if (i == 5) begin
        exp_v = FILL ? 1'b0 : 1'b1;
        total_cnt++; if (taps5 !== 8'h0) $display("FAIL clamp_partial_tap: got %0d expected %0d", taps5, 0); else pass_cnt++;
        total_cnt++; if (tv5 !== exp_v) $display("FAIL clamp_partial_valid: got %b expected %b", tv5, exp_v); else pass_cnt++;
      end
    end
    enable5 = 1'b0;
    tick();
    total_cnt++; if (taps5 !== 8'd2) $display("FAIL clamp_tap: got %0d expected %0d", taps5, 2); else pass_cnt++;
    total_cnt++; if (tv5 !== 1'b1) $display("FAIL clamp_valid: got %b expected %b", tv5, 1'b1); else pass_cnt++;
    total_cnt++; if (serie5 !== 8'd2) $display("FAIL clamp_serie: got %0d expected %0d", serie5, 2); else pass_cnt++;
    total_cnt++; if (lleno5 !== 1'b1) $display("FAIL clamp_lleno: got %b expected %b", lleno5, 1'b1); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; enable = 1'b0; din = '0; sel = '0;
    enable5 = 1'b0; clear5 = 1'b0; din5 = '0; sel5 = '0;
    test_reset();
    test_fill();
    test_wrap();
    test_hold();
    test_clear();
    test_clamp_odd();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
